// File: rtl/tx_pacing_scheduler_if.sv
// Handshake and status bundle between the pacing scheduler and its surrounding logic.
// The master drives the run controls and transmitter busy; the slave is the scheduler.
interface tx_pacing_scheduler_if #(
  parameter int PKT_CNT_W = 32
);
  logic                 enable;
  logic [3:0]           rate_sel;
  logic [7:0]           burst_len;
  logic                 tx_busy;
  logic                 start_sending;
  logic [PKT_CNT_W-1:0] pkt_count;
  logic [15:0]          overrun_count;
  logic                 timeout_err;
  logic                 burst_done;

  modport master (
    output enable, rate_sel, burst_len, tx_busy,
    input  start_sending, pkt_count, overrun_count, timeout_err, burst_done
  );

  modport slave (
    input  enable, rate_sel, burst_len, tx_busy,
    output start_sending, pkt_count, overrun_count, timeout_err, burst_done
  );
endinterface

// File: rtl/tx_pacing_scheduler.sv
// Paces Ethernet frame starts in the nibble clock domain: rate ticks, ACK timeout, IFG, bursts.
// Optional build macro SCHED_JITTER_EN adds LFSR jitter (0..15 cycles) to each tick period.
module tx_pacing_scheduler #(
  parameter int CNT_W       = 25,
  parameter int IFG_NIBBLES = 24,
  parameter int ACK_TIMEOUT = 64,
  parameter int PKT_CNT_W   = 32
) (
  input  logic                  nibble_clk,
  input  logic                  rst,
  tx_pacing_scheduler_if.slave  sched
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(IFG_NIBBLES + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, SENDING, GAP} state_t;

  function automatic logic [CNT_W-1:0] max_count_f(input logic [3:0] sel);
    case (sel)
      4'd0:    max_count_f = CNT_W'(24999999);
      4'd1:    max_count_f = CNT_W'(12499999);
      4'd2:    max_count_f = CNT_W'(2499999);
      4'd3:    max_count_f = CNT_W'(1249999);
      4'd4:    max_count_f = CNT_W'(499999);
      4'd5:    max_count_f = CNT_W'(249999);
      4'd6:    max_count_f = CNT_W'(124999);
      4'd7:    max_count_f = CNT_W'(49999);
      4'd8:    max_count_f = CNT_W'(24999);
      4'd9:    max_count_f = CNT_W'(12499);
      4'd10:   max_count_f = CNT_W'(4999);
      4'd11:   max_count_f = CNT_W'(2499);
      4'd12:   max_count_f = CNT_W'(999);
      4'd13:   max_count_f = CNT_W'(499);
      4'd14:   max_count_f = CNT_W'(249);
      default: max_count_f = '0;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic [3:0]           rate_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     eff_max;
  logic                 en_q;
  logic [ACK_W-1:0]     ack_cnt_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic [7:0]           burst_cnt_q;
  logic                 burst_done_q;
  logic [PKT_CNT_W-1:0] pkt_count_q;
  logic [15:0]          overrun_q;
  logic                 timeout_q;

  logic rate_chg, tick, accept, overrun, tx_fall, ack_expired, gap_done;

`ifdef SCHED_JITTER_EN
  logic [15:0] lfsr_q;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, stepped once per tick.
  always_ff @(posedge nibble_clk) begin
    if (rst)       lfsr_q <= 16'hACE1;
    else if (tick) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign eff_max = max_count_f(rate_q) + CNT_W'(lfsr_q[3:0]);
`else
  assign eff_max = max_count_f(rate_q);
`endif

  // A rate change restarts the period and swallows any coincident tick.
  assign rate_chg    = (sched.rate_sel != rate_q);
  assign tick        = sched.enable && !rate_chg && (cnt_q == eff_max);
  assign accept      = tick && !burst_done_q && !sched.tx_busy && (state_q == IDLE);
  assign overrun     = tick && !burst_done_q && !accept;
  assign tx_fall     = (state_q == SENDING) && !sched.tx_busy;
  assign ack_expired = (state_q == WAIT_ACK) && !sched.tx_busy &&
                       (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));
  assign gap_done    = (state_q == GAP) && !sched.tx_busy &&
                       (gap_cnt_q >= GAP_W'(IFG_NIBBLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge nibble_clk) begin
    if (rst) begin
      rate_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      rate_q <= sched.rate_sel;
      en_q   <= sched.enable;
      if (!sched.enable || rate_chg || (cnt_q == eff_max)) cnt_q <= '0;
      else                                                 cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge nibble_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = START;
      START:    state_d = WAIT_ACK;
      WAIT_ACK: if (sched.tx_busy) state_d = SENDING;
                else if (ack_expired) state_d = IDLE;
      SENDING:  if (!sched.tx_busy) state_d = GAP;
      GAP:      if (gap_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    sched.start_sending = (state_q == START);
  end

  // The fall cycle itself is the first idle nibble of the gap.
  always_ff @(posedge nibble_clk) begin
    if (rst) begin
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      if (state_q == WAIT_ACK) ack_cnt_q <= ack_cnt_q + ACK_W'(1);
      else                     ack_cnt_q <= '0;
      if (tx_fall)                               gap_cnt_q <= GAP_W'(1);
      else if (state_q == GAP && sched.tx_busy)  gap_cnt_q <= '0;
      else if (state_q == GAP)                   gap_cnt_q <= gap_cnt_q + GAP_W'(1);
    end
  end

  always_ff @(posedge nibble_clk) begin
    if (rst) begin
      pkt_count_q  <= '0;
      overrun_q    <= '0;
      timeout_q    <= 1'b0;
      burst_cnt_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      if (tx_fall)                          pkt_count_q <= pkt_count_q + PKT_CNT_W'(1);
      if (overrun && overrun_q != 16'hFFFF) overrun_q   <= overrun_q + 16'd1;
      if (ack_expired)                      timeout_q   <= 1'b1;
      if (en_q && !sched.enable) begin
        burst_cnt_q  <= '0;
        burst_done_q <= 1'b0;
      end else if (tx_fall) begin
        burst_cnt_q <= burst_cnt_q + 8'd1;
        if (sched.burst_len != 8'd0 && (burst_cnt_q + 8'd1) == sched.burst_len)
          burst_done_q <= 1'b1;
      end
    end
  end

  assign sched.pkt_count     = pkt_count_q;
  assign sched.overrun_count = overrun_q;
  assign sched.timeout_err   = timeout_q;
  assign sched.burst_done    = burst_done_q;

endmodule

// File: tb/tb_tx_pacing_scheduler.sv
// Scoreboard bench for tx_pacing_scheduler: expected start cycles are queued by the stimulus
// and checked by an independent monitor; status counters are checked at hand-computed cycles.
module tb_tx_pacing_scheduler;
  logic nibble_clk = 1'b0;
  logic rst;

  tx_pacing_scheduler_if #(.PKT_CNT_W(32)) sif ();

  tx_pacing_scheduler dut (
    .nibble_clk (nibble_clk),
    .rst        (rst),
    .sched      (sif)
  );

  always #20 nibble_clk = ~nibble_clk;

  int cyc = 0;
  always @(posedge nibble_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit tx_resp = 1'b1;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge nibble_clk);
  endtask

  // Monitor: every start pulse must match the next queued cycle.
  always @(negedge nibble_clk) begin
    if (sif.start_sending === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected start_sending", cyc, -1);
      else                   check("start_sending cycle", cyc, exp_q.pop_front());
    end
  end

  // Transmitter model: busy for 10 cycles starting 2 cycles after each start.
  initial begin
    sif.tx_busy = 1'b0;
    forever begin
      @(negedge nibble_clk);
      if (sif.start_sending === 1'b1 && tx_resp) begin
        repeat (2) @(negedge nibble_clk);
        sif.tx_busy = 1'b1;
        repeat (10) @(negedge nibble_clk);
        sif.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, d1, e0, f0, g0;
    rst = 1'b1;
    sif.enable = 1'b0;
    sif.rate_sel = 4'd0;
    sif.burst_len = 8'd0;
    repeat (3) @(negedge nibble_clk);
    check("reset start_sending", sif.start_sending, 0);
    check("reset pkt_count", sif.pkt_count, 0);
    check("reset overrun_count", sif.overrun_count, 0);
    check("reset timeout_err", sif.timeout_err, 0);
    check("reset burst_done", sif.burst_done, 0);
    rst = 1'b0;
    @(negedge nibble_clk);
    c0 = cyc;

    // Tick every cycle: starts every 37 cycles, all other ticks overrun.
    sif.rate_sel = 4'd15;
    sif.enable = 1'b1;
    exp_q.push_back(c0 + 2);
    exp_q.push_back(c0 + 39);
    exp_q.push_back(c0 + 76);
    wait_cyc(c0 + 14);  check("pkt before first fall", sif.pkt_count, 0);
    wait_cyc(c0 + 15);  check("pkt after first fall", sif.pkt_count, 1);
    wait_cyc(c0 + 100); check("pkt after three frames", sif.pkt_count, 3);
    sif.enable = 1'b0;
    wait_cyc(c0 + 120);
    check("overrun at rate 15", sif.overrun_count, 96);
    check("no timeout at rate 15", sif.timeout_err, 0);

    // Burst of 3 at period 250, then re-arm via enable.
    d0 = c0 + 130;
    wait_cyc(d0);
    sif.rate_sel = 4'd14;
    sif.burst_len = 8'd3;
    sif.enable = 1'b1;
    exp_q.push_back(d0 + 251);
    exp_q.push_back(d0 + 501);
    exp_q.push_back(d0 + 751);
    wait_cyc(d0 + 763); check("burst_done before last fall", sif.burst_done, 0);
    wait_cyc(d0 + 764); check("burst_done after 3 frames", sif.burst_done, 1);
    check("pkt after burst", sif.pkt_count, 6);
    d1 = d0 + 1010;
    wait_cyc(d1);
    check("tick ignored while burst_done", sif.overrun_count, 96);
    check("no extra frame after burst", sif.pkt_count, 6);
    sif.enable = 1'b0;
    wait_cyc(d1 + 1); check("burst_done cleared by enable low", sif.burst_done, 0);
    wait_cyc(d1 + 2);
    sif.enable = 1'b1;
    exp_q.push_back(d1 + 252);
    wait_cyc(d1 + 260);
    sif.enable = 1'b0;
    wait_cyc(d1 + 270); check("pkt after re-arm", sif.pkt_count, 7);

    // No transmitter response: ACK timeout, then the next tick starts again.
    e0 = d1 + 320;
    wait_cyc(e0);
    sif.burst_len = 8'd0;
    tx_resp = 1'b0;
    sif.enable = 1'b1;
    exp_q.push_back(e0 + 250);
    exp_q.push_back(e0 + 500);
    wait_cyc(e0 + 314); check("timeout_err before 64 cycles", sif.timeout_err, 0);
    wait_cyc(e0 + 315); check("timeout_err after 64 cycles", sif.timeout_err, 1);
    check("pkt unchanged on timeout", sif.pkt_count, 7);
    wait_cyc(e0 + 320);
    tx_resp = 1'b1;
    wait_cyc(e0 + 520);
    sif.enable = 1'b0;
    wait_cyc(e0 + 540);
    check("pkt after post-timeout frame", sif.pkt_count, 8);
    check("timeout_err sticky", sif.timeout_err, 1);
    check("overrun unchanged", sif.overrun_count, 96);

    // Rate change 13 -> 12 at count 300 restarts the period.
    f0 = e0 + 600;
    wait_cyc(f0);
    sif.rate_sel = 4'd13;
    sif.enable = 1'b1;
    wait_cyc(f0 + 301);
    sif.rate_sel = 4'd12;
    exp_q.push_back(f0 + 1302);
    wait_cyc(f0 + 1310);
    sif.enable = 1'b0;
    wait_cyc(f0 + 1340); check("pkt after rate change frame", sif.pkt_count, 9);

    // Reset while SENDING.
    g0 = f0 + 1400;
    wait_cyc(g0);
    sif.rate_sel = 4'd15;
    sif.enable = 1'b1;
    exp_q.push_back(g0 + 2);
    wait_cyc(g0 + 7);
    check("pkt before mid-frame reset", sif.pkt_count, 9);
    rst = 1'b1;
    sif.enable = 1'b0;
    wait_cyc(g0 + 8);
    check("mid-frame reset pkt_count", sif.pkt_count, 0);
    check("mid-frame reset overrun_count", sif.overrun_count, 0);
    check("mid-frame reset timeout_err", sif.timeout_err, 0);
    check("mid-frame reset burst_done", sif.burst_done, 0);
    check("mid-frame reset start_sending", sif.start_sending, 0);
    wait_cyc(g0 + 9);
    rst = 1'b0;
    wait_cyc(g0 + 30);
    check("busy release after reset not counted", sif.pkt_count, 0);
    check("missing start pulses", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tx_pacing_scheduler.md
Name: tx_pacing_scheduler

Overview:
- Sequences the Ethernet frame transmitter in the nibble clock domain: generates `start_sending` at a selectable packet rate, tracks each frame through the transmitter's busy window, and enforces the inter-frame gap.
- Supports continuous or fixed-length bursts and counts sent, dropped (overrun) and timed-out requests.
- Sits between the switch/rate inputs and the transmitter's `start_sending` input.

Parameters:
- CNT_W, 25: period counter width.
- IFG_NIBBLES, 24: minimum idle cycles after `tx_busy` falls (96 bit times).
- ACK_TIMEOUT, 64: max cycles from start pulse to `tx_busy` rise.
- PKT_CNT_W, 32: width of `pkt_count`.

Ports:
- nibble_clk, input, 1: sole clock (25 MHz nibble clock).
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: scheduler run enable.
- rate_sel, input, 4: packet-rate select (period table below).
- burst_len, input, 8: packets per burst; 0 = continuous.
- tx_busy, input, 1: high while the transmitter is emitting a frame.
- start_sending, output, 1: one-cycle start pulse to the transmitter.
- pkt_count, output, PKT_CNT_W: frames completed, wrapping.
- overrun_count, output, 16: ticks dropped, saturating at 16'hFFFF.
- timeout_err, output, 1: sticky; set on ACK timeout.
- burst_done, output, 1: high once `burst_len` frames complete; cleared by `enable` low.

Behaviour:
- Reset values: all outputs 0, state IDLE, period counter 0.
- Period table (max_count by rate_sel 0..15): 24999999, 12499999, 2499999, 1249999, 499999, 249999, 124999, 49999, 24999, 12499, 4999, 2499, 999, 499, 249, 0.
- Period counter:
  - Counts 0..max_count while `enable`=1; a tick is the cycle where count==max_count, then count wraps to 0.
  - max_count=0 gives a tick every cycle.
  - `enable`=0 holds the counter at 0 and produces no ticks.
- rate_sel is registered. When the registered value changes, the counter is forced to 0 in the same cycle, with no tick that cycle.
- FSM states: IDLE, START, WAIT_ACK, SENDING, GAP.
- IDLE: on a tick, with `burst_done`=0 and `tx_busy`=0, go to START.
- START: `start_sending`=1 for exactly this one cycle, then go to WAIT_ACK. Latency is tick cycle +1.
- WAIT_ACK:
  - `tx_busy`=1 goes to SENDING.
  - If ACK_TIMEOUT cycles elapse without it, set `timeout_err` and go to IDLE; no packet is counted.
- SENDING: on `tx_busy` falling (1→0), increment `pkt_count`, increment the burst counter, and go to GAP.
- GAP: hold IFG_NIBBLES cycles with no start, then go to IDLE.
  - A `tx_busy`=1 during GAP restarts the gap count.
- Overrun: a tick arriving in any state other than IDLE, or in IDLE while `tx_busy`=1, is dropped and increments `overrun_count` (saturating). A tick dropped in IDLE does not also start a frame.
- Burst:
  - With burst_len≠0, `burst_done` sets when the burst counter reaches burst_len.
  - While `burst_done` is set, ticks are ignored and not counted as overruns.
  - `enable` 1→0 clears `burst_done` and the burst counter.
- `enable` low mid-frame: the FSM finishes the current frame (WAIT_ACK/SENDING/GAP) and then rests in IDLE; no new starts are issued.
- `rst` mid-frame: immediate return to reset values; `tx_busy` is ignored until IDLE.
- Simultaneous events:
  - Tick and rate change in the same cycle: the rate change wins and the tick is suppressed.
  - `tx_busy` fall and tick in the same cycle: the fall is counted and the tick counts as an overrun.

Optional Feature:
- Macro: SCHED_JITTER_EN.
- Defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances once per tick.
  - The effective period becomes max_count + lfsr[3:0], so the counter wraps at that value.
  - Tick rate therefore varies by 0..15 cycles.
- Undefined: period is exactly max_count+1 cycles and no LFSR logic exists.

Test Plan:
- rate_sel=15, enable=1, transmitter model with 10-cycle busy starting 2 cycles after start → `start_sending` pulses spaced 2+10+24+1 cycles; each extra tick in between increments `overrun_count`.
- rate_sel=14 (249), burst_len=3 → exactly 3 start pulses 250 cycles apart, `burst_done`=1, `pkt_count`=3; `enable` 0→1 re-arms.
- `tx_busy` held 0 after a start → `timeout_err`=1 after 64 cycles, `pkt_count` unchanged, next tick starts a new frame.
- Change rate_sel from 13 to 12 at count 300 → counter resets, no tick in that cycle, next tick 1000 cycles later.
- `rst` asserted during SENDING → next cycle all outputs 0, state IDLE; busy release afterwards does not increment `pkt_count`.
- With SCHED_JITTER_EN, rate_sel=14 → tick intervals in 250..265 and matching the LFSR sequence; without the macro, all intervals equal 250.
